// File: rtl/wb_uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// wb_uart_tx_pkg
// Shared definitions for the Wishbone UART transmitter slice.
//   - Register offsets, decoded from wb_adr_i[3:2]
//   - STATUS register bit positions
//   - TX serialiser state encoding
// No ports. Imported by wb_uart_tx.
// ---------------------------------------------------------------------------
package wb_uart_tx_pkg;

    // Word offsets of the four registers (byte address bits [3:2])
    localparam logic [1:0] REG_DATA     = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_DIVISOR  = 2'd2;
    localparam logic [1:0] REG_IRQ_CTRL = 2'd3;

    // STATUS layout: [0] full, [1] empty, [2] busy, [15:8] FIFO level
    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_LEVEL_LSB = 8;

    // Serialiser states; every non-IDLE state lasts DIVISOR+1 clocks
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/wb_uart_fifo.sv
// ---------------------------------------------------------------------------
// wb_uart_fifo
// Synchronous single-clock FIFO, written generically so it can be reused for
// a receive path later.
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset (empties the FIFO)
//   push   in   write request; ignored when full (pre-pop level)
//   wdata  in   WIDTH-bit write data
//   pop    in   read request; ignored when empty
//   rdata  out  head-of-queue data (valid when !empty)
//   full   out  level == DEPTH
//   empty  out  level == 0
//   level  out  number of stored entries, 0..DEPTH
// DEPTH must be a power of two and >= 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module wb_uart_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int LW   = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    // Full is judged on the level before any same-cycle pop, so a push into
    // a full FIFO is dropped even while the head is being popped.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    assign rdata = mem[rd_ptr];

    // Storage array needs no reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and level bookkeeping; pointers wrap modulo DEPTH
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/wb_uart_tx.sv
// ---------------------------------------------------------------------------
// wb_uart_tx
// Wishbone slave UART transmitter (8N1, LSB first) with a TX FIFO.
// Registers (wb_adr_i[3:2]):
//   0 DATA     W: push wb_dat_i[7:0] when sel[0]; reads 0
//   1 STATUS   R: [0] full, [1] empty, [2] busy, [15:8] level
//   2 DIVISOR  RW [15:0], byte lanes sel[1:0]; bit period = DIVISOR+1 clocks
//   3 IRQ_CTRL RW [0] tx-empty interrupt enable (only with WB_UART_TX_IRQ_EN)
// Ports:
//   wb_clk_i, wb_reset_i (sync, active high), wb_adr_i, wb_dat_i, wb_dat_o,
//   wb_we_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_ack_o (single-cycle ack),
//   uart_tx_o (idle high), irq_o
// Build option: define WB_UART_TX_IRQ_EN to add the IRQ enable flop and a
// registered irq_o; otherwise irq_o is tied low and IRQ_CTRL reads 0.
// ---------------------------------------------------------------------------
module wb_uart_tx
    import wb_uart_tx_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int DEFAULT_DIV = 415
) (
    input  logic            wb_clk_i,
    input  logic            wb_reset_i,
    input  logic [AW-1:0]   wb_adr_i,
    input  logic [DW-1:0]   wb_dat_i,
    output logic [DW-1:0]   wb_dat_o,
    input  logic            wb_we_i,
    input  logic [DW/8-1:0] wb_sel_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    output logic            wb_ack_o,
    output logic            uart_tx_o,
    output logic            irq_o
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic          req;
    logic          wr_req;
    logic [1:0]    reg_sel;
    logic [DW-1:0] rd_data;
    logic [15:0]   divisor;

    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;

    tx_state_t     state, state_next;
    logic [15:0]   cnt, cnt_next;
    logic [15:0]   div_lat, div_lat_next;
    logic [2:0]    bit_cnt, bit_cnt_next;
    logic [7:0]    shift, shift_next;
    logic          tx_q, tx_next;
    logic          busy;

    logic          unused_ok;
    assign unused_ok = ^{wb_adr_i[AW-1:4], wb_adr_i[1:0],
                         wb_dat_i[DW-1:16], wb_sel_i[DW/8-1:2]};

    // A new request is only accepted while no ack is outstanding, which
    // gives exactly one ack cycle per transfer even if cyc/stb stay high.
    assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr_req  = req & wb_we_i;
    assign reg_sel = wb_adr_i[3:2];

    assign fifo_push = wr_req & (reg_sel == REG_DATA) & wb_sel_i[0];
    assign busy      = (state != TX_IDLE);
    assign uart_tx_o = tx_q;

    wb_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (wb_clk_i),
        .reset (wb_reset_i),
        .push  (fifo_push),
        .wdata (wb_dat_i[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

`ifdef WB_UART_TX_IRQ_EN
    logic irq_en;
    logic irq_q;

    // Interrupt enable register and the registered tx-empty interrupt
    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
            irq_en <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (wr_req && (reg_sel == REG_IRQ_CTRL) && wb_sel_i[0]) begin
                irq_en <= wb_dat_i[0];
            end
            irq_q <= irq_en & fifo_empty & ~busy;
        end
    end
    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    // Read mux; unmapped bits read as zero
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_STATUS: begin
                rd_data[STAT_FULL]               = fifo_full;
                rd_data[STAT_EMPTY]              = fifo_empty;
                rd_data[STAT_BUSY]               = busy;
                rd_data[STAT_LEVEL_LSB +: 8]     = 8'(fifo_level);
            end
            REG_DIVISOR: rd_data[15:0] = divisor;
`ifdef WB_UART_TX_IRQ_EN
            REG_IRQ_CTRL: rd_data[0] = irq_en;
`endif
            default: rd_data = '0;
        endcase
    end

    // Bus handshake; read data is registered and cleared outside ack cycles
    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= req;
            wb_dat_o <= (req && !wb_we_i) ? rd_data : '0;
        end
    end

    // Baud divisor register with per-byte-lane writes
    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
            divisor <= 16'(DEFAULT_DIV);
        end else if (wr_req && (reg_sel == REG_DIVISOR)) begin
            if (wb_sel_i[0]) divisor[7:0]  <= wb_dat_i[7:0];
            if (wb_sel_i[1]) divisor[15:8] <= wb_dat_i[15:8];
        end
    end

    // Serialiser next-state logic. The divisor is latched when a byte is
    // popped, so DIVISOR writes during a frame only affect the next frame.
    // The line value is computed from the next state and registered, so
    // uart_tx_o changes on the same edge as the state.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        div_lat_next = div_lat;
        bit_cnt_next = bit_cnt;
        shift_next   = shift;
        fifo_pop     = 1'b0;
        tx_next      = 1'b1;
        case (state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    shift_next   = fifo_rdata;
                    div_lat_next = divisor;
                    cnt_next     = divisor;
                    state_next   = TX_START;
                end
            end
            TX_START: begin
                if (cnt == 16'd0) begin
                    cnt_next     = div_lat;
                    bit_cnt_next = 3'd0;
                    state_next   = TX_DATA;
                end else begin
                    cnt_next = cnt - 16'd1;
                end
            end
            TX_DATA: begin
                if (cnt == 16'd0) begin
                    cnt_next = div_lat;
                    if (bit_cnt == 3'd7) begin
                        state_next = TX_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                        shift_next   = {1'b0, shift[7:1]};
                    end
                end else begin
                    cnt_next = cnt - 16'd1;
                end
            end
            TX_STOP: begin
                if (cnt == 16'd0) begin
                    state_next = TX_IDLE;
                end else begin
                    cnt_next = cnt - 16'd1;
                end
            end
            default: state_next = TX_IDLE;
        endcase
        case (state_next)
            TX_START: tx_next = 1'b0;
            TX_DATA:  tx_next = shift_next[0];
            default:  tx_next = 1'b1;
        endcase
    end

    // Serialiser state register; reset drops any frame in progress
    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
            state   <= TX_IDLE;
            cnt     <= 16'd0;
            div_lat <= 16'd0;
            bit_cnt <= 3'd0;
            shift   <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            div_lat <= div_lat_next;
            bit_cnt <= bit_cnt_next;
            shift   <= shift_next;
            tx_q    <= tx_next;
        end
    end

endmodule

// File: tb/tb_wb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_wb_uart_tx
// Directed self-checking bench for wb_uart_tx. The serial line and irq are
// recorded once per clock into history arrays indexed by cycle number, and
// each scenario compares stretches of that history with waveforms built
// from hand-derived frame timing.
// Define WB_UART_TX_IRQ_EN to exercise the interrupt build.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_uart_tx;

    localparam logic [3:0] A_DATA = 4'h0;
    localparam logic [3:0] A_STAT = 4'h4;
    localparam logic [3:0] A_DIV  = 4'h8;
    localparam logic [3:0] A_IRQ  = 4'hC;
    localparam int HIST = 8192;

    logic        wb_clk_i = 1'b0;
    logic        wb_reset_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;
    logic        uart_tx_o;
    logic        irq_o;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    logic tx_hist  [0:HIST-1];
    logic irq_hist [0:HIST-1];

    wb_uart_tx #(
        .AW (32), .DW (32), .FIFO_DEPTH (16), .DEFAULT_DIV (415)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_reset_i (wb_reset_i),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_we_i    (wb_we_i),
        .wb_sel_i   (wb_sel_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_ack_o   (wb_ack_o),
        .uart_tx_o  (uart_tx_o),
        .irq_o      (irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Cycle index: cycle k begins at the k-th rising edge
    always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

    // Record line and irq mid-cycle, away from the active edge
    always @(negedge wb_clk_i) begin
        if (cyc_cnt < HIST) begin
            tx_hist[cyc_cnt]  = uart_tx_o;
            irq_hist[cyc_cnt] = irq_o;
        end
    end

    // Safety net so the run can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc_cnt);
        $fatal(1, "[TB] watchdog");
    end

    // Reference 8N1 waveform: bit k is the expected line k clocks after the
    // start bit begins; bits past the frame are idle-high.
    function automatic logic [255:0] frame_wave(input logic [7:0] b, input int div);
        logic [255:0] w;
        int per;
        w   = '1;
        per = div + 1;
        for (int k = 0; k < 10 * per; k++) begin
            int idx;
            idx = k / per;
            if (idx == 0)      w[k] = 1'b0;
            else if (idx == 9) w[k] = 1'b1;
            else               w[k] = b[idx-1];
        end
        return w;
    endfunction

    // Recorded line from cycle 'start' for 'len' clocks, high beyond that
    function automatic logic [255:0] captured(input int start, input int len);
        logic [255:0] w;
        w = '1;
        for (int k = 0; k < len; k++) begin
            if (start + k < HIST) w[k] = tx_hist[start + k];
        end
        return w;
    endfunction

    // One Wishbone write; returns the cycle index of the ack cycle
    task automatic wb_write(input logic [3:0] adr, input logic [31:0] data,
                            input logic [3:0] sel, output int ack_cyc);
        @(posedge wb_clk_i); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = {28'h0, adr}; wb_dat_i = data; wb_sel_i = sel;
        @(posedge wb_clk_i); #1;
        ack_cyc = cyc_cnt;
        checks++;
        if (wb_ack_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL write_ack adr=%h got %b want 1", adr, wb_ack_o);
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_sel_i = 4'h0;
    endtask

    // One Wishbone read; data captured in the ack cycle
    task automatic wb_read(input logic [3:0] adr, output logic [31:0] data);
        @(posedge wb_clk_i); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = {28'h0, adr}; wb_sel_i = 4'hF;
        @(posedge wb_clk_i); #1;
        data = wb_dat_o;
        checks++;
        if (wb_ack_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL read_ack adr=%h got %b want 1", adr, wb_ack_o);
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_sel_i = 4'h0;
    endtask

    // Reset values and register defaults
    task automatic test_reset();
        logic [31:0] d;
        wb_reset_i = 1'b1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
        repeat (4) @(posedge wb_clk_i);
        #1 wb_reset_i = 1'b0;
        checks++;
        if ({wb_ack_o, wb_dat_o, uart_tx_o, irq_o} !== {1'b0, 32'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_outputs ack=%b dat=%h tx=%b irq=%b want 0/0/1/0",
                     wb_ack_o, wb_dat_o, uart_tx_o, irq_o);
        end
        wb_read(A_STAT, d);
        checks++;
        if (d !== 32'h0000_0002) begin
            errors++; $display("[TB] FAIL reset_status got %h want 00000002", d);
        end
        wb_read(A_DIV, d);
        checks++;
        if (d !== 32'd415) begin
            errors++; $display("[TB] FAIL reset_divisor got %0d want 415", d);
        end
        wb_read(A_DATA, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("[TB] FAIL data_read got %h want 0", d);
        end
    endtask

    // Request held high for three cycles must ack, idle, ack
    task automatic test_ack_hold();
        logic [2:0]  acks;
        logic [31:0] d1;
        @(posedge wb_clk_i); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = {28'h0, A_DIV}; wb_sel_i = 4'hF;
        @(posedge wb_clk_i); #1 acks[2] = wb_ack_o; d1 = wb_dat_o;
        @(posedge wb_clk_i); #1 acks[1] = wb_ack_o;
        @(posedge wb_clk_i); #1 acks[0] = wb_ack_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        checks++;
        if (acks !== 3'b101) begin
            errors++; $display("[TB] FAIL ack_pattern got %b want 101", acks);
        end
        checks++;
        if (d1 !== 32'd415) begin
            errors++; $display("[TB] FAIL held_read_data got %0d want 415", d1);
        end
    endtask

    // Single byte 0x55 at DIVISOR=3: 40-clock frame starting at T+2
    task automatic test_basic();
        int a, c;
        logic [31:0]  d;
        logic [255:0] exp_w, act_w;
        wb_write(A_DIV, 32'd3, 4'b0011, c);
        wb_write(A_DATA, 32'h55, 4'b0001, a);
        wb_read(A_STAT, d);
        checks++;
        if (d !== 32'h0000_0006) begin
            errors++; $display("[TB] FAIL busy_status got %h want 00000006", d);
        end
        repeat (45) @(posedge wb_clk_i);
        #1;
        exp_w = frame_wave(8'h55, 3);
        exp_w = {exp_w[254:0], 1'b1};
        act_w = captured(a, 42);
        checks++;
        if (act_w !== exp_w) begin
            errors++;
            $display("[TB] FAIL frame_55 got %h want %h", act_w[63:0], exp_w[63:0]);
        end
        wb_read(A_STAT, d);
        checks++;
        if (d !== 32'h0000_0002) begin
            errors++; $display("[TB] FAIL idle_status got %h want 00000002", d);
        end
        checks++;
        if (irq_o !== 1'b0 && !`ifdef WB_UART_TX_IRQ_EN 1'b1 `else 1'b0 `endif) begin
            errors++; $display("[TB] FAIL irq_default got %b want 0", irq_o);
        end
    endtask

    // Long first frame keeps the FIFO from draining: 16 queue, the 17th
    // queued write is dropped. Then DIVISOR=0 drains the 16 at 11 clks each.
    task automatic test_burst();
        int a1, c, base;
        logic [31:0]  d;
        logic [255:0] exp_w, act_w;
        wb_write(A_DIV, 32'd200, 4'b0011, c);
        wb_write(A_DATA, 32'hFF, 4'b0001, a1);
        for (int k = 1; k <= 17; k++) begin
            wb_write(A_DATA, 32'(8'hA0 + k), 4'b0001, c);
        end
        wb_read(A_STAT, d);
        checks++;
        if (d !== 32'h0000_1005) begin
            errors++; $display("[TB] FAIL full_status got %h want 00001005", d);
        end
        wb_write(A_DIV, 32'd0, 4'b0011, c);
        base = a1 + 2012;
        for (int w = 0; w < 5000 && cyc_cnt < base + 16 * 11 + 25; w++) begin
            @(posedge wb_clk_i);
        end
        #1;
        for (int k = 1; k <= 16; k++) begin
            exp_w = frame_wave(8'(8'hA0 + k), 0);
            act_w = captured(base + (k - 1) * 11, 11);
            checks++;
            if (act_w !== exp_w) begin
                errors++;
                $display("[TB] FAIL burst_frame_%0d got %h want %h", k, act_w[15:0], exp_w[15:0]);
            end
        end
        act_w = captured(base + 16 * 11, 20);
        checks++;
        if (act_w !== {256{1'b1}}) begin
            errors++; $display("[TB] FAIL dropped_byte_sent got %h want fffff", act_w[19:0]);
        end
        wb_read(A_STAT, d);
        checks++;
        if (d !== 32'h0000_0002) begin
            errors++; $display("[TB] FAIL drained_status got %h want 00000002", d);
        end
    endtask

    // Two queued bytes at DIVISOR=1: 20-clk frames with one idle clock between
    task automatic test_back_to_back();
        int a, c;
        logic [255:0] exp_w, act_w;
        wb_write(A_DIV, 32'd1, 4'b0001, c);
        wb_write(A_DATA, 32'h3C, 4'b0001, a);
        wb_write(A_DATA, 32'hC3, 4'b0001, c);
        repeat (50) @(posedge wb_clk_i);
        #1;
        exp_w = frame_wave(8'h3C, 1);
        exp_w = {exp_w[254:0], 1'b1};
        act_w = captured(a, 22);
        checks++;
        if (act_w !== exp_w) begin
            errors++; $display("[TB] FAIL b2b_first got %h want %h", act_w[31:0], exp_w[31:0]);
        end
        exp_w = frame_wave(8'hC3, 1);
        act_w = captured(a + 22, 21);
        checks++;
        if (act_w !== exp_w) begin
            errors++; $display("[TB] FAIL b2b_second got %h want %h", act_w[31:0], exp_w[31:0]);
        end
    endtask

    // DIVISOR change mid-frame only applies to the following frame
    task automatic test_div_midframe();
        int a, c;
        logic [31:0]  d;
        logic [255:0] exp_w, act_w;
        wb_write(A_DIV, 32'd3, 4'b0011, c);
        wb_write(A_DATA, 32'h0F, 4'b0001, a);
        wb_write(A_DIV, 32'd7, 4'b0001, c);
        wb_write(A_DATA, 32'hF0, 4'b0001, c);
        repeat (130) @(posedge wb_clk_i);
        #1;
        exp_w = frame_wave(8'h0F, 3);
        act_w = captured(a + 1, 41);
        checks++;
        if (act_w !== exp_w) begin
            errors++; $display("[TB] FAIL mid_old_div got %h want %h", act_w[63:0], exp_w[63:0]);
        end
        exp_w = frame_wave(8'hF0, 7);
        act_w = captured(a + 42, 81);
        checks++;
        if (act_w !== exp_w) begin
            errors++; $display("[TB] FAIL mid_new_div got %h want %h", act_w[95:0], exp_w[95:0]);
        end
        wb_read(A_DIV, d);
        checks++;
        if (d !== 32'd7) begin
            errors++; $display("[TB] FAIL divisor_readback got %0d want 7", d);
        end
    endtask

    // Interrupt behaviour (build dependent) and reset in the middle of a frame
    task automatic test_irq_and_reset();
        int a, c;
        logic [31:0] d;
        wb_write(A_DIV, 32'd1, 4'b0011, c);
        wb_write(A_IRQ, 32'd1, 4'b0001, c);
        wb_read(A_IRQ, d);
`ifdef WB_UART_TX_IRQ_EN
        checks++;
        if (d !== 32'd1) begin
            errors++; $display("[TB] FAIL irq_ctrl_read got %h want 1", d);
        end
        @(posedge wb_clk_i); #1;
        checks++;
        if (irq_o !== 1'b1) begin
            errors++; $display("[TB] FAIL irq_idle got %b want 1", irq_o);
        end
        wb_write(A_DATA, 32'hA5, 4'b0001, a);
        repeat (30) @(posedge wb_clk_i);
        #1;
        checks++;
        if ({irq_hist[a + 1], irq_hist[a + 21], irq_hist[a + 22]} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL irq_timing got %b%b%b want 001",
                     irq_hist[a + 1], irq_hist[a + 21], irq_hist[a + 22]);
        end
`else
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("[TB] FAIL irq_ctrl_read got %h want 0", d);
        end
        repeat (3) @(posedge wb_clk_i);
        #1;
        checks++;
        if (irq_o !== 1'b0) begin
            errors++; $display("[TB] FAIL irq_tied got %b want 0", irq_o);
        end
`endif
        wb_write(A_DATA, 32'h00, 4'b0001, a);
        repeat (5) @(posedge wb_clk_i);
        #1;
        checks++;
        if (uart_tx_o !== 1'b0) begin
            errors++; $display("[TB] FAIL midframe_line got %b want 0", uart_tx_o);
        end
        wb_reset_i = 1'b1;
        @(posedge wb_clk_i); #1;
        wb_reset_i = 1'b0;
        checks++;
        if ({uart_tx_o, irq_o} !== 2'b10) begin
            errors++; $display("[TB] FAIL reset_midframe tx=%b irq=%b want 1/0", uart_tx_o, irq_o);
        end
        repeat (30) @(posedge wb_clk_i);
        wb_read(A_STAT, d);
        checks++;
        if (d !== 32'h0000_0002 || irq_o !== 1'b0) begin
            errors++; $display("[TB] FAIL after_reset status=%h irq=%b want 00000002/0", d, irq_o);
        end
    endtask

    // Scenario sequence and summary
    initial begin
        $display("[TB] start");
        test_reset();
        test_ack_hold();
        test_basic();
        test_burst();
        test_back_to_back();
        test_div_midframe();
        test_irq_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
